mips_mc_controller: RTL and testbench

- Parametrised multicycle MIPS control unit with a memory wait-state handshake. It is the next generation of the current fixed-latency controller.
- Drives the datapath muxes, register enables and ALU control of the shared instruction/data memory core.
- Adds bne/addi/andi/ori/j support, a combined PC enable, memory-ready stalling with a timeout, illegal-instruction trapping and a retired-instruction counter.

---
 rtl/mips_mc_controller.sv | 237 +++++++++++++++++++++++
 tb/tb_mips_mc_controller.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit with memory wait-state handshake, stall
// timeout, illegal-instruction trap and retired-instruction counter.
module mips_mc_controller #(
  parameter int ALUCTRL_WIDTH = 3,
  parameter int MAX_WAIT      = 15,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [5:0]               Opcode,
  input  logic [5:0]               Funct,
  input  logic                     zero,
  input  logic                     mem_ready,
  output logic                     mem_req,
  output logic                     MemWrite,
  output logic                     lord,
  output logic                     IRWrite,
  output logic                     PCEn,
  output logic [1:0]               PCSrc,
  output logic                     ALUSrcA,
  output logic [1:0]               ALUSrcB,
  output logic [ALUCTRL_WIDTH-1:0] ALUControl,
  output logic                     RegDst,
  output logic                     MemtoReg,
  output logic                     RegWrite,
  output logic                     ExtZero,
  output logic                     err,
  output logic [1:0]               err_cause,
  output logic [CNT_WIDTH-1:0]     instr_count
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB   = 4'd4,  S_MEMWR  = 4'd5,  S_EXECUTE = 4'd6, S_ALUWB  = 4'd7,
    S_BRANCH  = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP   = 4'd11,
    S_ERROR   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [ALUCTRL_WIDTH-1:0] ALU_ADD = ALUCTRL_WIDTH'(3'b010);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SUB = ALUCTRL_WIDTH'(3'b110);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_AND = ALUCTRL_WIDTH'(3'b000);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_OR  = ALUCTRL_WIDTH'(3'b001);
  localparam logic [ALUCTRL_WIDTH-1:0] ALU_SLT = ALUCTRL_WIDTH'(3'b111);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Last tolerated stall count before a memory access traps.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t     state;
  state_t     next_state;
  logic [7:0] wait_cnt;
  logic       wait_inc;
  logic       retire;
  logic [1:0] trap_cause;

  // State, stall counter, trap record and retired-instruction counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_FETCH;
      wait_cnt    <= 8'd0;
      instr_count <= '0;
      err         <= 1'b0;
      err_cause   <= 2'b00;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_inc ? (wait_cnt + 8'd1) : 8'd0;
      if (retire) begin
        instr_count <= instr_count + CNT_WIDTH'(1);
      end
      if ((next_state == S_ERROR) && (state != S_ERROR)) begin
        err       <= 1'b1;
        err_cause <= trap_cause;
      end
    end
  end

  // Next-state and control decode; every output is held at 0 while rst is low.
  always_comb begin
    next_state = state;
    trap_cause = 2'b00;
    wait_inc   = 1'b0;
    retire     = 1'b0;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    lord       = 1'b0;
    IRWrite    = 1'b0;
    PCEn       = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = '0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ExtZero    = 1'b0;
    if (rst) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          ALUSrcB    = 2'b01;
          ALUControl = ALU_ADD;
          if (mem_ready) begin
            IRWrite    = 1'b1;
            PCEn       = 1'b1;
            next_state = S_DECODE;
          end else if (wait_cnt == WAIT_LAST) begin
            next_state = S_ERROR;
            trap_cause = CAUSE_TIMEOUT;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_DECODE: begin
          ALUSrcB    = 2'b11;
          ALUControl = ALU_ADD;
          case (Opcode)
            OP_LW, OP_SW:             next_state = S_MEMADR;
            OP_RTYPE:                 next_state = S_EXECUTE;
            OP_BEQ, OP_BNE:           next_state = S_BRANCH;
            OP_ADDI, OP_ANDI, OP_ORI: next_state = S_IMMEX;
            OP_J:                     next_state = S_JUMP;
            default: begin
              next_state = S_ERROR;
              trap_cause = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          ALUControl = ALU_ADD;
          if (Opcode == OP_SW) begin
            next_state = S_MEMWR;
          end else begin
            next_state = S_MEMRD;
          end
        end
        S_MEMRD, S_MEMWR: begin
          mem_req  = 1'b1;
          lord     = 1'b1;
          MemWrite = (state == S_MEMWR);
          if (mem_ready) begin
            next_state = (state == S_MEMWR) ? S_FETCH : S_MEMWB;
            retire     = (state == S_MEMWR);
          end else if (wait_cnt == WAIT_LAST) begin
            next_state = S_ERROR;
            trap_cause = CAUSE_TIMEOUT;
          end else begin
            wait_inc = 1'b1;
          end
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_EXECUTE: begin
          ALUSrcA    = 1'b1;
          next_state = S_ALUWB;
          case (Funct)
            6'b100000: ALUControl = ALU_ADD;
            6'b100010: ALUControl = ALU_SUB;
            6'b100100: ALUControl = ALU_AND;
            6'b100101: ALUControl = ALU_OR;
            6'b101010: ALUControl = ALU_SLT;
            default: begin
              next_state = S_ERROR;
              trap_cause = CAUSE_ILLEGAL;
            end
          endcase
        end
        S_ALUWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUControl = ALU_SUB;
          PCSrc      = 2'b01;
          PCEn       = (Opcode == OP_BNE) ? ~zero : zero;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_IMMEX: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = 2'b10;
          next_state = S_IMMWB;
          case (Opcode)
            OP_ANDI: begin
              ALUControl = ALU_AND;
              ExtZero    = 1'b1;
            end
            OP_ORI: begin
              ALUControl = ALU_OR;
              ExtZero    = 1'b1;
            end
            default: ALUControl = ALU_ADD;
          endcase
        end
        S_IMMWB: begin
          RegWrite   = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          PCSrc      = 2'b10;
          PCEn       = 1'b1;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
        S_ERROR: next_state = S_ERROR;
        default: begin
          next_state = S_ERROR;
          trap_cause = CAUSE_ILLEGAL;
        end
      endcase
    end else begin
      next_state = S_FETCH;
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomised self-checking bench for mips_mc_controller. Expected control
// vectors are built per instruction class from the controller's published
// behaviour; the DUT runs with MAX_WAIT=4 and a 4-bit counter so that the
// timeout and wrap boundaries are reachable quickly.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Opcode = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, lord, IRWrite, PCEn, ALUSrcA;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegDst, MemtoReg, RegWrite, ExtZero, err;
  logic [1:0] err_cause;
  logic [3:0] instr_count;

  mips_mc_controller #(.ALUCTRL_WIDTH(3), .MAX_WAIT(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .lord(lord),
    .IRWrite(IRWrite), .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ExtZero(ExtZero), .err(err),
    .err_cause(err_cause), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Observed control vector, same field order as mk().
  logic [19:0] outs;
  assign outs = {mem_req, MemWrite, lord, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                 ALUControl, RegDst, MemtoReg, RegWrite, ExtZero, err, err_cause};

  int passed = 0;
  int total  = 0;
  int cnt_m  = 0;

  logic [19:0] exp_q[$];
  logic        rdy_q[$];
  bit          chk_q[$];
  logic [19:0] obs_q[$];
  logic        zero_in;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101, JMP = 6'b000010;
  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, AND_ = 3'b000, OR_ = 3'b001, SLT = 3'b111;

  function automatic logic [19:0] mk(input logic mreq, input logic mw, input logic ld,
                                     input logic irw, input logic pce, input logic [1:0] pcs,
                                     input logic asa, input logic [1:0] asb, input logic [2:0] alu,
                                     input logic rd, input logic m2r, input logic rw,
                                     input logic ez);
    return {mreq, mw, ld, irw, pce, pcs, asa, asb, alu, rd, m2r, rw, ez, 1'b0, 2'b00};
  endfunction

  function automatic logic [19:0] err_vec(input logic [1:0] cause);
    return {17'd0, 1'b1, cause};
  endfunction

  function automatic logic [2:0] alu_of_funct(input logic [5:0] fn);
    case (fn)
      6'b100000: return ADD;
      6'b100010: return SUB;
      6'b100100: return AND_;
      6'b100101: return OR_;
      default:   return SLT;
    endcase
  endfunction

  task automatic push(input logic [19:0] v, input logic r, input bit c);
    exp_q.push_back(v);
    rdy_q.push_back(r);
    chk_q.push_back(c);
  endtask

  task automatic clear_q();
    exp_q.delete(); rdy_q.delete(); chk_q.delete(); obs_q.delete();
  endtask

  // Memory access of n stall cycles followed by the completing cycle.
  task automatic push_access(input logic [19:0] v, input int n);
    for (int i = 0; i < n; i++) push(v, 1'b0, 1'b1);
    push(v, 1'b1, 1'b1);
  endtask

  // Reference: expected cycle-by-cycle controls of one legal instruction.
  task automatic model_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int sf, input int sm);
    logic r;
    r = 1'($urandom_range(0, 1));
    for (int i = 0; i < sf; i++) push(mk(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0), 1'b0, 1'b1);
    push(mk(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0), 1'b1, 1'b1);
    push(mk(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0), r, 1'b1);
    case (op)
      LW: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0), r, 1'b1);
        push_access(mk(1,0,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0), sm);
        push(mk(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,1,1,0), r, 1'b1);
      end
      SW: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b10,ADD,0,0,0,0), r, 1'b1);
        push_access(mk(1,1,1,0,0,2'b00,0,2'b00,3'b000,0,0,0,0), sm);
      end
      RT: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b00,alu_of_funct(fn),0,0,0,0), r, 1'b1);
        push(mk(0,0,0,0,0,2'b00,0,2'b00,3'b000,1,0,1,0), r, 1'b1);
      end
      BEQ, BNE: push(mk(0,0,0,0,(op == BNE) ? !z : z,2'b01,1,2'b00,SUB,0,0,0,0), r, 1'b1);
      ADDI, ANDI, ORI: begin
        push(mk(0,0,0,0,0,2'b00,1,2'b10,(op == ADDI) ? ADD : ((op == ANDI) ? AND_ : OR_),
                0,0,0,(op != ADDI)), r, 1'b1);
        push(mk(0,0,0,0,0,2'b00,0,2'b00,3'b000,0,0,1,0), r, 1'b1);
      end
      default: push(mk(0,0,0,0,1,2'b10,0,2'b00,3'b000,0,0,0,0), r, 1'b1);
    endcase
    cnt_m = (cnt_m + 1) % 16;
  endtask

  // Drive the queued mem_ready pattern and capture outputs mid-cycle.
  task automatic run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = rdy_q[i];
      zero      = zero_in;
      @(negedge clk);
      obs_q.push_back(outs);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    cnt_m = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== 20'd0) $display("FAIL reset_outputs got=%h exp=%h", outs, 20'd0);
    else passed++;
    total++;
    if (instr_count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", instr_count);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1; cnt_m = 0;
  endtask

  task automatic test_seq(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic z, input int sf, input int sm);
    clear_q();
    zero_in = z; Opcode = op; Funct = fn;
    model_instr(op, fn, z, sf, sm);
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL %s cycle%0d got=%h exp=%h", name, i + 1, obs_q[i], exp_q[i]);
      else passed++;
    end
    total++;
    if (instr_count !== 4'(cnt_m)) $display("FAIL %s_count got=%0d exp=%0d", name, instr_count, cnt_m);
    else passed++;
  endtask

  task automatic test_random();
    logic [5:0] ops [9] = '{LW, SW, RT, BEQ, BNE, ADDI, ANDI, ORI, JMP};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 40; n++)
      test_seq("random", ops[$urandom_range(0, 8)], fns[$urandom_range(0, 4)],
               1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 16; n++) test_seq("wrap", JMP, 6'd0, 1'b0, 0, 0);
    total++;
    if (instr_count !== 4'd0) $display("FAIL wrap_zero got=%0d exp=0", instr_count);
    else passed++;
  endtask

  // Trap scenarios: illegal opcode, illegal funct and fetch timeout.
  task automatic test_trap(input string name, input int kind);
    logic [19:0] fetch_v;
    do_reset();
    clear_q();
    zero_in = 1'b0;
    fetch_v = mk(1,0,0,0,0,2'b00,0,2'b01,ADD,0,0,0,0);
    if (kind == 2) begin
      Opcode = LW; Funct = 6'd0;
      for (int i = 0; i < 4; i++) push(fetch_v, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) push(err_vec(2'b10), 1'(i % 2), 1'b1);
    end else begin
      Opcode = (kind == 0) ? 6'b111111 : RT;
      Funct  = 6'b000001;
      push(mk(1,0,0,1,1,2'b00,0,2'b01,ADD,0,0,0,0), 1'b1, 1'b1);
      push(mk(0,0,0,0,0,2'b00,0,2'b11,ADD,0,0,0,0), 1'b0, 1'b1);
      if (kind == 1) push(20'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) push(err_vec(2'b01), 1'(i % 2), 1'b1);
    end
    run_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (chk_q[i]) begin
        total++;
        if (obs_q[i] !== exp_q[i])
          $display("FAIL %s cycle%0d got=%h exp=%h", name, i + 1, obs_q[i], exp_q[i]);
        else passed++;
      end
    end
    total++;
    if (instr_count !== 4'd0) $display("FAIL %s_count_frozen got=%0d exp=0", name, instr_count);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    Opcode = SW; Funct = 6'd0; zero = 1'b0;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (MemWrite !== 1'b1) $display("FAIL midwr_active got=%b exp=1", MemWrite);
    else passed++;
    #2 rst = 1'b0;
    #1;
    total++;
    if (outs !== 20'd0) $display("FAIL midwr_async_drop got=%h exp=%h", outs, 20'd0);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b1; cnt_m = 0;
    test_seq("after_midwr", JMP, 6'd0, 1'b0, 0, 0);
  endtask

  initial begin
    zero_in = 1'b0;
    fork
      begin
        test_reset();
        test_seq("lw", LW, 6'd0, 1'b0, 0, 0);
        test_seq("fetch_stall", JMP, 6'd0, 1'b0, 3, 0);
        test_seq("bne_z0", BNE, 6'd0, 1'b0, 0, 0);
        test_seq("beq_z0", BEQ, 6'd0, 1'b0, 0, 0);
        test_seq("ori", ORI, 6'd0, 1'b0, 0, 0);
        test_seq("sw_stall", SW, 6'd0, 1'b0, 0, 3);
        test_random();
        test_trap("illegal_opcode", 0);
        test_trap("illegal_funct", 1);
        test_trap("timeout", 2);
        test_wrap();
        test_reset_mid_write();
      end
      begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
      end
    join_any
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
